muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes.
// Fixed latency of WIDTH+1 cycles from start-accept to the done pulse, independent of operands.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits or quotient bits
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

  always_comb begin
    hi_nx = mul_sum[WIDTH:1];
    lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) begin
        hi_nx = div_diff[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = div_sh[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign sign_a = A[WIDTH-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign sign_b = B[WIDTH-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign mag_a  = sign_a ? -A : A;
  assign mag_b  = sign_b ? -B : B;

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nx : lo_nx;
    rem_s  = neg_q ? -hi_nx : hi_nx;
    if (op_q[2])
      final_res = op_q[1] ? rem_s : quo_s;
    else if (op_q == OP_MUL)
      final_res = prod_s[WIDTH-1:0];
    else
      final_res = prod_s[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op;
          hi_d    = '0;
          opnd_d  = op[2] ? mag_b : mag_a;
          lo_d    = op[2] ? mag_a : mag_b;
          // A zero divisor must yield an all-ones quotient, so the sign fix-up is suppressed.
          if (op == OP_DIV)
            neg_d = (sign_a ^ sign_b) & (|B);
          else if (op == OP_REM)
            neg_d = sign_a;
          else
            neg_d = sign_a ^ sign_b;
        end
      end
      CALC: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
